// File: rtl/knight_rider_pkg.sv
// Shared types and helpers for the knight-rider LED scan checker.
// Covers the tracker states, the violation codes and the bounce rule.
package knight_rider_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        NOT_ONEHOT   = 2'd1,
        BAD_STEP     = 2'd2,
        OUT_OF_RANGE = 2'd3
    } err_code_t;

    localparam int ERR_COUNT_MAX = 255;

    // Only legal successor of position p: bounce at either end, otherwise keep moving.
    function automatic int next_index(input int p, input logic up, input int lo, input int hi);
        int result;
        if (p == hi) begin
            result = hi - 1;
        end else if (p == lo) begin
            result = lo + 1;
        end else if (up) begin
            result = p + 1;
        end else begin
            result = p - 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational one-hot decoder: gives the lit index and whether exactly one bit is set.
// idx is only meaningful when is_onehot is high.
module onehot_decoder #(
    parameter int N_LEDS = 10,
    parameter int IDX_W  = $clog2(N_LEDS)
) (
    input  logic [N_LEDS-1:0] pattern,
    output logic [IDX_W-1:0]  idx,
    output logic              is_onehot
);

    // Bit b of the index is the OR of every LED whose position has bit b set.
    function automatic logic [N_LEDS-1:0] bit_mask(input int b);
        logic [N_LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            m[i] = ((i >> b) & 1) == 1;
        end
        return m;
    endfunction

    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_idx_bit
            localparam logic [N_LEDS-1:0] MASK = bit_mask(gi);
            assign idx[gi] = |(pattern & MASK);
        end
    endgenerate

    assign is_onehot = (pattern != '0) && ((pattern & (pattern - N_LEDS'(1))) == '0);

endmodule

// File: rtl/knight_rider_decoder.sv
// Receive-side checker for the bouncing one-hot LED scan: acquires lock on a legal
// sweep, tracks position and direction, counts end arrivals and protocol violations.
module knight_rider_decoder
    import knight_rider_pkg::*;
#(
    parameter int N_LEDS     = 10,
    parameter int LO_POS     = 0,
    parameter int HI_POS     = 9,
    parameter int LOCK_STEPS = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = $clog2(N_LEDS)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [N_LEDS-1:0] pattern,
    output logic [IDX_W-1:0]  pos,
    output logic              dir_up,
    output logic              locked,
    output logic [CNT_W-1:0]  sweep_count,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        err_count
);

    localparam int STEP_W = $clog2(LOCK_STEPS + 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   pos_reg, pos_next;
    logic               dir_reg, dir_next;
    logic               locked_reg, locked_next;
    logic [STEP_W-1:0]  steps_reg, steps_next;
    logic [CNT_W-1:0]   sweep_reg, sweep_next;
    logic               err_reg, err_next;
    err_code_t          code_reg, code_next;
    logic [7:0]         errcnt_reg, errcnt_next;

    logic [IDX_W-1:0]   dec_idx;
    logic               dec_onehot;

    onehot_decoder #(
        .N_LEDS (N_LEDS),
        .IDX_W  (IDX_W)
    ) u_decoder (
        .pattern   (pattern),
        .idx       (dec_idx),
        .is_onehot (dec_onehot)
    );

    // Signed integer views keep range checks and +/-1 arithmetic free of unsigned wrap.
    int   idx_int;
    int   pos_int;
    int   want_int;
    logic in_range;
    logic step_up;
    logic step_dn;
    logic step_legal;
    logic acq_ok;
    logic lock_reached;
    logic at_end;

    assign idx_int      = int'(dec_idx);
    assign pos_int      = int'(pos_reg);
    assign want_int     = next_index(pos_int, dir_reg, LO_POS, HI_POS);
    assign in_range     = dec_onehot && (idx_int >= LO_POS) && (idx_int <= HI_POS);
    assign step_up      = (idx_int == pos_int + 1);
    assign step_dn      = (idx_int == pos_int - 1);
    assign step_legal   = dec_onehot && (idx_int == want_int);
    // The first acquisition step may go either way; it establishes the direction.
    assign acq_ok       = (steps_reg == '0) ? (in_range && (step_up || step_dn)) : step_legal;
    assign lock_reached = (int'(steps_reg) + 1 >= LOCK_STEPS);
    assign at_end       = (idx_int == LO_POS) || (idx_int == HI_POS);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg  <= UNLOCKED;
            pos_reg    <= '0;
            dir_reg    <= 1'b0;
            locked_reg <= 1'b0;
            steps_reg  <= '0;
            sweep_reg  <= '0;
            err_reg    <= 1'b0;
            code_reg   <= NONE;
            errcnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pos_reg    <= pos_next;
            dir_reg    <= dir_next;
            locked_reg <= locked_next;
            steps_reg  <= steps_next;
            sweep_reg  <= sweep_next;
            err_reg    <= err_next;
            code_reg   <= code_next;
            errcnt_reg <= errcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (sample_en) begin
            unique case (state_reg)
                UNLOCKED: begin
                    if (in_range) begin
                        state_next = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (acq_ok) begin
                        if (lock_reached) begin
                            state_next = LOCKED;
                        end
                    end else if (!in_range) begin
                        state_next = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!step_legal) begin
                        state_next = UNLOCKED;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        pos_next    = pos_reg;
        dir_next    = dir_reg;
        steps_next  = steps_reg;
        sweep_next  = sweep_reg;
        err_next    = 1'b0;
        code_next   = code_reg;
        errcnt_next = errcnt_reg;
        locked_next = (state_next == LOCKED);
        if (sample_en) begin
            unique case (state_reg)
                UNLOCKED: begin
                    if (in_range) begin
                        pos_next   = dec_idx;
                        steps_next = '0;
                    end
                end
                ACQUIRE: begin
                    if (acq_ok) begin
                        pos_next   = dec_idx;
                        dir_next   = step_up;
                        steps_next = steps_reg + STEP_W'(1);
                    end else if (in_range) begin
                        // Restart acquisition anchored on this sample.
                        pos_next   = dec_idx;
                        steps_next = '0;
                    end
                end
                LOCKED: begin
                    if (step_legal) begin
                        pos_next = dec_idx;
                        dir_next = step_up;
                        if (at_end) begin
                            sweep_next = sweep_reg + CNT_W'(1);
                        end
                    end else begin
                        err_next = 1'b1;
                        if (!dec_onehot) begin
                            code_next = NOT_ONEHOT;
                        end else if (!in_range) begin
                            code_next = OUT_OF_RANGE;
                        end else begin
                            code_next = BAD_STEP;
                        end
                        if (errcnt_reg != 8'(ERR_COUNT_MAX)) begin
                            errcnt_next = errcnt_reg + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pos         = pos_reg;
    assign dir_up      = dir_reg;
    assign locked      = locked_reg;
    assign sweep_count = sweep_reg;
    assign err         = err_reg;
    assign err_code    = code_reg;
    assign err_count   = errcnt_reg;

endmodule

// File: tb/tb_knight_rider_decoder.sv
// Self-checking bench for knight_rider_decoder: directed scenarios plus a randomized
// run against a behavioural model of the scan protocol.
module tb_knight_rider_decoder;

    localparam int LO = 0;
    localparam int HI = 9;
    localparam int STEPS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en, sample_en2;
    logic [9:0]  pattern, pattern2;
    logic [3:0]  pos, pos2;
    logic        dir_up, dir_up2, locked, locked2, err, err2;
    logic [15:0] sweep_count, sweep_count2;
    logic [1:0]  err_code, err_code2;
    logic [7:0]  err_count, err_count2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (m_run < 0 means no anchor yet).
    int m_pos, m_run, m_code, m_sweep, m_errcnt;
    bit m_dir, m_locked, m_err;

    always #5 clk = ~clk;

    knight_rider_decoder dut (
        .CLOCK_50(clk), .reset(reset), .sample_en(sample_en), .pattern(pattern),
        .pos(pos), .dir_up(dir_up), .locked(locked), .sweep_count(sweep_count),
        .err(err), .err_code(err_code), .err_count(err_count)
    );

    knight_rider_decoder #(.LO_POS(1), .HI_POS(8)) dut2 (
        .CLOCK_50(clk), .reset(reset), .sample_en(sample_en2), .pattern(pattern2),
        .pos(pos2), .dir_up(dir_up2), .locked(locked2), .sweep_count(sweep_count2),
        .err(err2), .err_code(err_code2), .err_count(err_count2)
    );

    function automatic logic [9:0] oh(input int i);
        logic [9:0] v;
        v = '0;
        if (i >= 0 && i < 10) v[i] = 1'b1;
        return v;
    endfunction

    // Next legal position: keep moving, reflect off either end.
    function automatic int tb_next();
        int d;
        int c;
        d = m_dir ? 1 : -1;
        c = m_pos + d;
        if (c > HI || c < LO) c = m_pos - d;
        return c;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_run = -1; m_code = 0; m_sweep = 0; m_errcnt = 0;
        m_dir = 0; m_locked = 0; m_err = 0;
    endtask

    task automatic model_sample(input logic [9:0] p);
        int idx;
        bit one, inr, ok;
        idx = -1;
        for (int i = 0; i < 10; i++) if (p[i]) idx = i;
        one = ($countones(p) == 1);
        inr = one && idx >= LO && idx <= HI;
        m_err = 0;
        if (m_locked) begin
            if (one && idx == tb_next()) begin
                m_dir = idx > m_pos;
                m_pos = idx;
                if (idx == LO || idx == HI) m_sweep = (m_sweep + 1) % 65536;
            end else begin
                m_err = 1;
                m_code = !one ? 1 : (!inr ? 3 : 2);
                if (m_errcnt < 255) m_errcnt++;
                m_locked = 0;
                m_run = -1;
            end
        end else if (m_run < 0) begin
            if (inr) begin m_pos = idx; m_run = 0; end
        end else begin
            ok = inr && ((m_run == 0) ? (idx == m_pos + 1 || idx == m_pos - 1) : (idx == tb_next()));
            if (ok) begin
                m_dir = idx > m_pos;
                m_pos = idx;
                m_run++;
                if (m_run == STEPS) m_locked = 1;
            end else if (inr) begin
                m_pos = idx; m_run = 0;
            end else begin
                m_run = -1;
            end
        end
    endtask

    task automatic do_sample(input logic [9:0] p, input int idle);
        @(negedge clk);
        sample_en = 1'b1;
        pattern = p;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        model_sample(p);
        $display("sample pat=%b pos=%0d dir=%0b locked=%0b sweep=%0d err=%0b code=%0d errcnt=%0d",
                 p, pos, dir_up, locked, sweep_count, err, err_code, err_count);
        if (idle > 0) begin
            repeat (idle) @(posedge clk);
            #1;
            m_err = 0;
        end
    endtask

    task automatic sample2(input logic [9:0] p);
        @(negedge clk);
        sample_en2 = 1'b1;
        pattern2 = p;
        @(posedge clk);
        #1;
        sample_en2 = 1'b0;
        $display("sample2 pat=%b pos=%0d dir=%0b locked=%0b sweep=%0d err=%0b code=%0d errcnt=%0d",
                 p, pos2, dir_up2, locked2, sweep_count2, err2, err_code2, err_count2);
    endtask

    task automatic lock_run(input int from, input int to);
        int step;
        step = (from <= to) ? 1 : -1;
        for (int i = from; i != to + step; i += step) do_sample(oh(i), 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_en = 1'b1;
        sample_en2 = 1'b1;
        pattern = oh(3);
        pattern2 = oh(3);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pos, dir_up, locked, sweep_count, err, err_code, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_dut: got %h required 0",
                     {pos, dir_up, locked, sweep_count, err, err_code, err_count});
        end
        checks++;
        if ({pos2, dir_up2, locked2, sweep_count2, err2, err_code2, err_count2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: got %h required 0",
                     {pos2, dir_up2, locked2, sweep_count2, err2, err_code2, err_count2});
        end
        @(negedge clk);
        reset = 1'b0;
        sample_en = 1'b0;
        sample_en2 = 1'b0;
        model_reset();
    endtask

    task automatic test_sweep();
        int v, exp_sweep;
        bit exp_dir;
        for (int k = 0; k <= 18; k++) begin
            v = (k <= 9) ? k : 18 - k;
            do_sample(oh(v), 3);
            exp_dir = (k >= 1 && k <= 9);
            exp_sweep = (k < 9) ? 0 : ((k < 18) ? 1 : 2);
            checks++;
            if (pos !== 4'(v)) begin
                errors++; $display("FAIL sweep_pos k=%0d: got %0d required %0d", k, pos, v);
            end
            checks++;
            if (locked !== (k >= 4)) begin
                errors++; $display("FAIL sweep_locked k=%0d: got %0b required %0b", k, locked, k >= 4);
            end
            checks++;
            if (dir_up !== exp_dir) begin
                errors++; $display("FAIL sweep_dir k=%0d: got %0b required %0b", k, dir_up, exp_dir);
            end
            checks++;
            if (sweep_count !== 16'(exp_sweep) || err !== 1'b0) begin
                errors++; $display("FAIL sweep_count k=%0d: got %0d err=%0b required %0d err=0",
                                   k, sweep_count, err, exp_sweep);
            end
        end
    endtask

    task automatic test_not_onehot();
        logic [9:0] bad [2];
        bad[0] = 10'b0000000000;
        bad[1] = 10'b0000011000;
        for (int r = 0; r < 2; r++) begin
            lock_run(r == 0 ? 1 : 0, 5);
            checks++;
            if (!(locked === 1'b1 && pos === 4'd5 && dir_up === 1'b1)) begin
                errors++; $display("FAIL onehot_prelock: got locked=%0b pos=%0d dir=%0b required 1 5 1",
                                   locked, pos, dir_up);
            end
            do_sample(bad[r], 0);
            checks++;
            if (!(err === 1'b1 && err_code === 2'd1 && locked === 1'b0 && pos === 4'd5)) begin
                errors++; $display("FAIL onehot_err: got err=%0b code=%0d locked=%0b pos=%0d required 1 1 0 5",
                                   err, err_code, locked, pos);
            end
            checks++;
            if (err_count !== 8'(r + 1)) begin
                errors++; $display("FAIL onehot_errcnt: got %0d required %0d", err_count, r + 1);
            end
            @(posedge clk); #1; m_err = 0;
            checks++;
            if (err !== 1'b0 || err_code !== 2'd1) begin
                errors++; $display("FAIL onehot_pulse: got err=%0b code=%0d required 0 1", err, err_code);
            end
        end
    endtask

    task automatic test_bad_step();
        for (int s = 0; s < 3; s++) begin
            if (s == 0) begin
                lock_run(0, 4); do_sample(oh(6), 0);
            end else if (s == 1) begin
                lock_run(0, 9); do_sample(oh(9), 0);
            end else begin
                lock_run(6, 2); lock_run(1, 0); lock_run(1, 2);
                checks++;
                if (!(locked === 1'b1 && pos === 4'd2 && dir_up === 1'b1)) begin
                    errors++; $display("FAIL badstep_prelock: got locked=%0b pos=%0d dir=%0b required 1 2 1",
                                       locked, pos, dir_up);
                end
                do_sample(oh(1), 0);
            end
            checks++;
            if (!(err === 1'b1 && err_code === 2'd2 && locked === 1'b0)) begin
                errors++; $display("FAIL badstep_err s=%0d: got err=%0b code=%0d locked=%0b required 1 2 0",
                                   s, err, err_code, locked);
            end
            checks++;
            if (pos !== 4'(m_pos) || err_count !== 8'(m_errcnt)) begin
                errors++; $display("FAIL badstep_hold s=%0d: got pos=%0d errcnt=%0d required %0d %0d",
                                   s, pos, err_count, m_pos, m_errcnt);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 1; i <= 8; i++) sample2(oh(i));
        for (int i = 7; i >= 1; i--) sample2(oh(i));
        checks++;
        if (!(locked2 === 1'b1 && pos2 === 4'd1 && dir_up2 === 1'b0 && sweep_count2 === 16'd2)) begin
            errors++; $display("FAIL oor_prelock: got locked=%0b pos=%0d dir=%0b sweep=%0d required 1 1 0 2",
                               locked2, pos2, dir_up2, sweep_count2);
        end
        sample2(oh(0));
        checks++;
        if (!(err2 === 1'b1 && err_code2 === 2'd3 && locked2 === 1'b0 && err_count2 === 8'd1 && pos2 === 4'd1)) begin
            errors++; $display("FAIL oor_err: got err=%0b code=%0d locked=%0b errcnt=%0d pos=%0d required 1 3 0 1 1",
                               err2, err_code2, locked2, err_count2, pos2);
        end
    endtask

    task automatic test_idle();
        logic [31:0] snap, now;
        lock_run(0, 6);
        @(posedge clk); #1; m_err = 0;
        snap = {pos, dir_up, locked, sweep_count, err_code, err_count};
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            pattern = 10'($urandom);
            pattern2 = 10'($urandom);
            @(posedge clk); #1;
            now = {pos, dir_up, locked, sweep_count, err_code, err_count};
            checks++;
            if (now !== snap || err !== 1'b0) begin
                errors++; $display("FAIL idle c=%0d: got %h err=%0b required %h err=0", c, now, err, snap);
            end
        end
    endtask

    task automatic test_random();
        int r, v;
        logic [9:0] p;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80 && (m_locked || m_run > 0)) begin
                p = oh(tb_next());
            end else if (r < 80 && m_run == 0) begin
                if (m_pos == LO) v = m_pos + 1;
                else if (m_pos == HI) v = m_pos - 1;
                else v = ($urandom_range(0, 1) == 1) ? m_pos + 1 : m_pos - 1;
                p = oh(v);
            end else if (r < 90) begin
                p = oh($urandom_range(0, 9));
            end else if (r < 95) begin
                p = '0;
            end else begin
                v = $urandom_range(0, 9);
                p = oh(v) | oh((v + 1 + $urandom_range(0, 8)) % 10);
            end
            do_sample(p, $urandom_range(0, 2));
            checks++;
            if (pos !== 4'(m_pos) || dir_up !== m_dir) begin
                errors++; $display("FAIL rnd_posdir n=%0d: got %0d/%0b required %0d/%0b", n, pos, dir_up, m_pos, m_dir);
            end
            checks++;
            if (locked !== m_locked) begin
                errors++; $display("FAIL rnd_locked n=%0d: got %0b required %0b", n, locked, m_locked);
            end
            checks++;
            if (sweep_count !== 16'(m_sweep)) begin
                errors++; $display("FAIL rnd_sweep n=%0d: got %0d required %0d", n, sweep_count, m_sweep);
            end
            checks++;
            if (err !== m_err || err_code !== 2'(m_code)) begin
                errors++; $display("FAIL rnd_err n=%0d: got %0b/%0d required %0b/%0d", n, err, err_code, m_err, m_code);
            end
            checks++;
            if (err_count !== 8'(m_errcnt)) begin
                errors++; $display("FAIL rnd_errcnt n=%0d: got %0d required %0d", n, err_count, m_errcnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        lock_run(0, 6);
        @(negedge clk);
        reset = 1'b1;
        sample_en = 1'b1;
        pattern = oh(7);
        @(posedge clk); #1;
        checks++;
        if ({pos, dir_up, locked, sweep_count, err, err_code, err_count} !== '0) begin
            errors++; $display("FAIL reset_mid: got %h required 0",
                               {pos, dir_up, locked, sweep_count, err, err_code, err_count});
        end
        @(negedge clk);
        reset = 1'b0;
        sample_en = 1'b0;
        model_reset();
    endtask

    task automatic test_err_saturation();
        int want;
        for (int i = 1; i <= 300; i++) begin
            lock_run(0, 4);
            do_sample(oh(0), 0);
            want = (i < 255) ? i : 255;
            checks++;
            if (err_count !== 8'(want) || err_code !== 2'd2) begin
                errors++; $display("FAIL sat i=%0d: got errcnt=%0d code=%0d required %0d 2", i, err_count, err_code, want);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_en = 1'b0;
        sample_en2 = 1'b0;
        pattern = '0;
        pattern2 = '0;
        model_reset();
        test_reset();
        test_sweep();
        test_not_onehot();
        test_bad_step();
        test_out_of_range();
        test_idle();
        test_random();
        test_reset_mid();
        test_err_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
